// File: rtl/hex_word_pkg.sv
// Shared types and constants for the HEX word display scheduler.
// Word codes match the select encoding of the existing combinational word decoder.
package hex_word_pkg;

  typedef logic [2:0] word_t;

  localparam word_t WORD_PHONE = 3'b000;
  localparam word_t WORD_DRESS = 3'b001;
  localparam word_t WORD_CHAIR = 3'b011;
  localparam word_t WORD_BED   = 3'b100;
  localparam word_t WORD_OIL   = 3'b101;
  localparam word_t WORD_BEAR  = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  // 3'b010 and 3'b111 have no decoder pattern behind them.
  function automatic logic word_legal(input word_t w);
    return (w != 3'b010) && (w != 3'b111);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past 'pointer' and
// wraps modulo N. The first asserted request wins.
module rr_arbiter
  import hex_word_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] pointer,
  output logic [N-1:0]  win,
  output logic          any
);

  always_comb begin
    int idx;
    idx = 0;
    win = '0;
    any = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(pointer) + k) % N;
      if (!any && req[idx]) begin
        win[idx] = 1'b1;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hex_word_scheduler.sv
// Time-shares the HEX word display between requesters: round-robin grant, hold
// the word for HOLD_TICKS display ticks, then blank for GAP_TICKS.
module hex_word_scheduler
  import hex_word_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int HOLD_TICKS = 3,
  parameter int GAP_TICKS  = 1,
  parameter int CW         = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               clear,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*3-1:0] word_in,
  output logic [2:0]         word_sel,
  output logic               word_valid,
  output logic [N_REQ-1:0]   grant,
  output logic               busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  word_t            sel_q, sel_d;
  logic             valid_q, valid_d;
  logic [N_REQ-1:0] grant_q, grant_d;

  logic [N_REQ-1:0] win;
  logic             any;
  logic [PW-1:0]    win_idx;
  word_t            win_word;
  logic             last_tick;

  rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (
    .req     (req),
    .pointer (ptr_q),
    .win     (win),
    .any     (any)
  );

  always_comb begin
    win_idx  = '0;
    win_word = WORD_PHONE;
    for (int i = 0; i < N_REQ; i++) begin
      if (win[i]) begin
        win_idx  = PW'(i);
        win_word = word_in[3*i +: 3];
      end
    end
  end

  assign last_tick = tick && (cnt_q == CW'(1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (any) state_d = SHOW;
        SHOW:    if (last_tick) state_d = (GAP_TICKS == 0) ? IDLE : GAP;
        GAP:     if (last_tick) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    grant_d = '0;
    if (clear) begin
      cnt_d   = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_d = 1'b0;
          if (any) begin
            grant_d = win;
            ptr_d   = win_idx;
            cnt_d   = CW'(HOLD_TICKS);
            // Undefined codes are timed normally but never reach the decoder.
            valid_d = word_legal(win_word);
            sel_d   = word_legal(win_word) ? win_word : WORD_PHONE;
          end
        end
        SHOW: begin
          if (last_tick) begin
            valid_d = 1'b0;
            cnt_d   = CW'(GAP_TICKS);
          end else if (tick) begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        GAP: begin
          valid_d = 1'b0;
          if (last_tick)  cnt_d = '0;
          else if (tick)  cnt_d = cnt_q - CW'(1);
        end
        default: begin
          valid_d = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= PW'(N_REQ - 1);
      cnt_q   <= '0;
      sel_q   <= WORD_PHONE;
      valid_q <= 1'b0;
      grant_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      grant_q <= grant_d;
    end
  end

  assign word_sel   = sel_q;
  assign word_valid = valid_q;
  assign grant      = grant_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_hex_word_scheduler.sv
// Scoreboard bench for hex_word_scheduler with default parameters
// (4 requesters, hold 3 ticks, gap 1 tick).
module tb_hex_word_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick;
  logic        clear;
  logic [3:0]  req;
  logic [11:0] word_in;
  logic [2:0]  word_sel;
  logic        word_valid;
  logic [3:0]  grant;
  logic        busy;

  typedef struct {
    logic [3:0] g;
    logic [2:0] s;
    logic       v;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   gtimes[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc_cnt = 0;
  bit   slow    = 1'b0;

  hex_word_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .clear      (clear),
    .req        (req),
    .word_in    (word_in),
    .word_sel   (word_sel),
    .word_valid (word_valid),
    .grant      (grant),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_cnt);
    end
  endtask

  // Advance one cycle: drive tick just after the edge, return at the negedge.
  task automatic step();
    @(posedge clk);
    #1;
    tick = slow ? ((cyc_cnt % 5) == 0) : 1'b1;
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [3:0] g, input logic [2:0] s, input logic v);
    exp_t x;
    x.g = g; x.s = s; x.v = v;
    sbq.push_back(x);
  endtask

  task automatic set_word(input int i, input logic [2:0] w);
    word_in[3*i +: 3] = w;
  endtask

  task automatic count_run(input int n, output int nv, output int nb, output int nsel);
    nv = 0; nb = 0; nsel = 0;
    for (int i = 0; i < n; i++) begin
      if (word_valid) nv++;
      if (busy) nb++;
      if (word_sel != 3'b000) nsel++;
      step();
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 40 && busy; k++) step();
    chk(tag, 32'(busy), 32'h0);
  endtask

  always @(negedge clk) begin
    if (grant != 4'b0000) begin
      gtimes.push_back(cyc_cnt);
      if (sbq.size() == 0) begin
        chk("grant_unexpected", 32'(grant), 32'h0);
      end else begin
        e = sbq.pop_front();
        chk("grant", 32'(grant), 32'(e.g));
        chk("word_sel", 32'(word_sel), 32'(e.s));
        chk("word_valid", 32'(word_valid), 32'(e.v));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nv, nb, nsel, g, c, ticks, t3, t4;
    reset = 1'b1; tick = 1'b1; clear = 1'b0; req = 4'b0; word_in = 12'h0;
    repeat (3) step();
    chk("rst_word_sel", 32'(word_sel), 32'h0);
    chk("rst_valid", 32'(word_valid), 32'h0);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    step();

    // Basic word from requester 0.
    set_word(0, 3'b011);
    push_exp(4'b0001, 3'b011, 1'b1);
    req = 4'b0001;
    step();
    req = 4'b0000;
    count_run(5, nv, nb, nsel);
    chk("s1_valid_cycles", 32'(nv), 32'd3);
    chk("s1_busy_cycles", 32'(nb), 32'd4);
    chk("s1_idle", 32'(busy), 32'h0);

    // Two requesters held continuously alternate.
    set_word(1, 3'b100);
    set_word(3, 3'b110);
    for (int i = 0; i < 2; i++) begin
      push_exp(4'b0010, 3'b100, 1'b1);
      push_exp(4'b1000, 3'b110, 1'b1);
    end
    gtimes.delete();
    req = 4'b1010;
    repeat (17) step();
    req = 4'b0000;
    repeat (5) step();
    chk("s2_grant_count", 32'(gtimes.size()), 32'd4);
    for (int i = 1; i < 4 && i < gtimes.size(); i++)
      chk("s2_grant_spacing", 32'(gtimes[i] - gtimes[i-1]), 32'd5);
    chk("s2_idle", 32'(busy), 32'h0);

    // Undefined code is granted and timed but blanked.
    set_word(2, 3'b111);
    push_exp(4'b0100, 3'b000, 1'b0);
    req = 4'b0100;
    step();
    req = 4'b0000;
    count_run(5, nv, nb, nsel);
    chk("s3_valid_cycles", 32'(nv), 32'd0);
    chk("s3_busy_cycles", 32'(nb), 32'd4);
    chk("s3_sel_nonzero", 32'(nsel), 32'd0);

    // Slow tick: one every 5 cycles.
    slow = 1'b1;
    set_word(0, 3'b101);
    push_exp(4'b0001, 3'b101, 1'b1);
    req = 4'b0001;
    step();
    req = 4'b0000;
    g = cyc_cnt;
    chk("s4_grant", 32'(grant), 32'h1);
    c = g; ticks = 0;
    while (ticks < 3) begin
      if ((c % 5) == 0) ticks++;
      c++;
    end
    t3 = c - 1;
    t4 = t3 + 1;
    while ((t4 % 5) != 0) t4++;
    nv = 0; nb = 0;
    for (int k = 0; k < 40 && busy; k++) begin
      if (word_valid) nv++;
      nb++;
      step();
    end
    chk("s4_timeout", 32'(busy), 32'h0);
    chk("s4_valid_cycles", 32'(nv), 32'(t3 - g + 1));
    chk("s4_busy_cycles", 32'(nb), 32'(t4 - g + 1));
    slow = 1'b0;
    step();

    // Clear two cycles into SHOW, with a request waiting.
    set_word(1, 3'b001);
    push_exp(4'b0010, 3'b001, 1'b1);
    req = 4'b0010;
    step();
    req = 4'b0000;
    step();
    clear = 1'b1;
    req = 4'b1000;
    push_exp(4'b1000, 3'b110, 1'b1);
    step();
    clear = 1'b0;
    chk("s5_clear_valid", 32'(word_valid), 32'h0);
    chk("s5_clear_busy", 32'(busy), 32'h0);
    chk("s5_clear_grant", 32'(grant), 32'h0);
    step();
    chk("s5_regrant_busy", 32'(busy), 32'h1);
    req = 4'b0000;
    wait_idle("s5_idle_timeout");
    step();

    // Reset together with clear during GAP restores the pointer.
    push_exp(4'b0010, 3'b001, 1'b1);
    req = 4'b0010;
    step();
    req = 4'b0000;
    repeat (3) step();
    chk("s6_in_gap_busy", 32'(busy), 32'h1);
    chk("s6_in_gap_valid", 32'(word_valid), 32'h0);
    reset = 1'b1;
    clear = 1'b1;
    step();
    chk("s6_rst_word_sel", 32'(word_sel), 32'h0);
    chk("s6_rst_valid", 32'(word_valid), 32'h0);
    chk("s6_rst_grant", 32'(grant), 32'h0);
    chk("s6_rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    clear = 1'b0;
    push_exp(4'b0001, 3'b101, 1'b1);
    req = 4'b1111;
    step();
    req = 4'b0000;
    wait_idle("s6_idle_timeout");
    repeat (2) step();

    chk("sb_empty", 32'(sbq.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
